csr_mfile: RTL and testbench

Parametrised machine/user-mode CSR file and trap unit, the successor of the single-cycle CSR block at the commit point of the pipeline. It accepts one committing instruction per handshake and executes CSR read-modify-write operations, ECALL, MRET, synchronous exceptions and interrupts. It has an NIRQ-wide interrupt vector with fixed priority, and holds a registered redirect to fetch until fetch acknowledges it. It adds WARL masking, illegal-CSR detection, a minstret counter and optional vectored trap entry.

---
 rtl/csr_pkg.sv | 63 ++++++
 rtl/csr_irq_arbiter.sv | 25 ++
 rtl/csr_mfile.sv | 241 ++++++++++++++++++++++++
 tb/tb_csr_mfile.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine/user CSR file: addresses, op codes, causes,
// mstatus layout, FSM states and WARL write masks.
package csr_pkg;

  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  // Read-only user shadows of the machine counters.
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CSRRW = 3'd1,
    OP_CSRRS = 3'd2,
    OP_CSRRC = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_t;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef struct packed {
    logic [50:0] rsv_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsv_b;
    logic        mpie;
    logic [2:0]  rsv_a;
    logic        mie;
    logic [2:0]  rsv_lo;
  } mstatus_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } csr_state_e;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
  localparam logic [63:0] MTVEC_BASE_MASK = ~64'h3;

  function automatic logic csr_is_implemented(input logic [11:0] addr);
    case (addr)
      CSR_SATP, CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
      CSR_CYCLE, CSR_INSTRET: csr_is_implemented = 1'b1;
      default:                csr_is_implemented = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt picker: 11 > 3 > 7 > remaining lines by descending index.
module csr_irq_arbiter #(
  parameter int NIRQ = 12
) (
  input  logic [NIRQ-1:0] pend,
  output logic            hit,
  output logic [3:0]      cause
);

  logic [15:0] pend16;

  always_comb begin
    pend16 = 16'(pend);
    hit    = |pend16;
    cause  = 4'd0;
    // Ascending scan leaves the highest ordinary line; named lines override after.
    for (int i = 0; i < 16; i++) begin
      if (pend16[i] && i != 3 && i != 7 && i != 11) cause = 4'(i);
    end
    if (pend16[7])  cause = 4'd7;
    if (pend16[3])  cause = 4'd3;
    if (pend16[11]) cause = 4'd11;
  end

endmodule

// File: rtl/csr_mfile.sv
// Commit-point CSR file and trap unit with registered fetch redirect.
// Optional vectored interrupt entry is enabled by defining CSR_VECTORED_EN.
module csr_mfile
  import csr_pkg::*;
#(
  parameter int               XLEN      = 64,
  parameter int               NIRQ      = 12,
  parameter logic [XLEN-1:0]  RESET_VEC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     csr_ra,
  output logic [XLEN-1:0] csr_rd,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic            commit_stall,
  input  logic [XLEN-1:0] commit_pc,
  input  csr_op_t         commit_op,
  input  logic [11:0]     commit_csr,
  input  logic [XLEN-1:0] commit_wdata,
  input  logic            commit_wzero,
  input  logic            commit_exc,
  input  logic [3:0]      commit_cause,
  input  logic [XLEN-1:0] commit_tval,
  input  logic [NIRQ-1:0] irq,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush,
  output logic [1:0]      priv,
  output csr_state_e      dbg_state
);

  csr_state_e      state_q, state_d;
  logic [1:0]      priv_q, priv_d;
  mstatus_t        mst_q, mst_d;
  logic [NIRQ-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d, satp_q, satp_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic            redirect_valid_q, redirect_valid_d, flush_q, flush_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  function automatic logic [XLEN-1:0] rd_mux(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:              rd_mux = XLEN'(mst_q) & XLEN'(MSTATUS_WMASK);
      CSR_MIE:                  rd_mux = XLEN'(mie_q);
      CSR_MIP:                  rd_mux = XLEN'(irq);
      CSR_MTVEC:                rd_mux = mtvec_q;
      CSR_MSCRATCH:             rd_mux = mscratch_q;
      CSR_MEPC:                 rd_mux = {mepc_q[XLEN-1:2], 2'b00};
      CSR_MCAUSE:               rd_mux = mcause_q;
      CSR_MTVAL:                rd_mux = mtval_q;
      CSR_SATP:                 rd_mux = satp_q;
      CSR_MCYCLE, CSR_CYCLE:    rd_mux = mcycle_q;
      CSR_MINSTRET, CSR_INSTRET: rd_mux = minstret_q;
      default:                  rd_mux = '0;
    endcase
  endfunction

  logic            accept, irq_hit, irq_take, is_csr_op, csr_wr, illegal, vec_mode;
  logic [3:0]      irq_cause, trap_cause;
  logic            take_trap, trap_int, do_mret, do_csr;
  logic [XLEN-1:0] old_val, wval, trap_tval, tvec_base, target;

  csr_irq_arbiter #(.NIRQ(NIRQ)) u_arb (
    .pend  (irq & mie_q),
    .hit   (irq_hit),
    .cause (irq_cause)
  );

  assign commit_ready   = (state_q == ST_IDLE);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign priv           = priv_q;
  assign dbg_state      = state_q;
  assign csr_rd         = rd_mux(csr_ra);

`ifdef CSR_VECTORED_EN
  assign vec_mode = (mtvec_q[1:0] == 2'd1);
`else
  assign vec_mode = 1'b0;
`endif

  // Event selection: exactly one of trap / MRET / CSR op / plain retire per accept.
  always_comb begin
    accept    = commit_valid && commit_ready && !commit_stall;
    irq_take  = irq_hit && (priv_q == PRIV_U || mst_q.mie);
    is_csr_op = (commit_op == OP_CSRRW) || (commit_op == OP_CSRRS) || (commit_op == OP_CSRRC);
    csr_wr    = (commit_op == OP_CSRRW) ||
                (((commit_op == OP_CSRRS) || (commit_op == OP_CSRRC)) && !commit_wzero);
    illegal   = (is_csr_op && (!csr_is_implemented(commit_csr) ||
                               (csr_wr && commit_csr[11:10] == 2'b11) ||
                               (commit_csr[9:8] > priv_q))) ||
                (commit_op == OP_MRET && priv_q == PRIV_U);
    old_val   = rd_mux(commit_csr);
    case (commit_op)
      OP_CSRRS: wval = old_val | commit_wdata;
      OP_CSRRC: wval = old_val & ~commit_wdata;
      default:  wval = commit_wdata;
    endcase

    take_trap  = 1'b1;
    trap_int   = 1'b0;
    trap_cause = 4'd0;
    trap_tval  = '0;
    if (irq_take) begin
      trap_int   = 1'b1;
      trap_cause = irq_cause;
    end else if (commit_exc) begin
      trap_cause = commit_cause;
      trap_tval  = commit_tval;
    end else if (illegal) begin
      trap_cause = CAUSE_ILLEGAL;
    end else if (commit_op == OP_ECALL) begin
      trap_cause = (priv_q == PRIV_U) ? CAUSE_ECALL_U : CAUSE_ECALL_M;
    end else begin
      take_trap = 1'b0;
    end
    do_mret = !take_trap && (commit_op == OP_MRET);
    do_csr  = !take_trap && is_csr_op;

    tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    if (take_trap)
      target = tvec_base + ((vec_mode && trap_int) ? XLEN'({trap_cause, 2'b00}) : '0);
    else if (do_mret)
      target = {mepc_q[XLEN-1:2], 2'b00};
    else
      target = commit_pc + XLEN'(4);
  end

  always_comb begin
    state_d          = state_q;
    priv_d           = priv_q;
    mst_d            = mst_q;
    mie_d            = mie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    satp_d           = satp_q;
    mcycle_d         = mcycle_q + XLEN'(1);
    minstret_d       = minstret_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;

    if (state_q == ST_REDIRECT && redirect_ready) begin
      state_d          = ST_IDLE;
      redirect_valid_d = 1'b0;
    end

    if (accept) begin
      if (take_trap || do_mret || do_csr) begin
        state_d          = ST_REDIRECT;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target;
        flush_d          = 1'b1;
      end
      if (!take_trap) minstret_d = minstret_q + XLEN'(1);

      if (take_trap) begin
        mepc_d     = {commit_pc[XLEN-1:2], 2'b00};
        mcause_d   = {trap_int, {(XLEN-5){1'b0}}, trap_cause};
        mtval_d    = trap_tval;
        mst_d.mpie = mst_q.mie;
        mst_d.mie  = 1'b0;
        mst_d.mpp  = priv_q;
        priv_d     = PRIV_M;
      end else if (do_mret) begin
        priv_d     = mst_q.mpp;
        mst_d.mie  = mst_q.mpie;
        mst_d.mpie = 1'b1;
        mst_d.mpp  = PRIV_U;
      end else if (do_csr && csr_wr) begin
        // Counter writes land after the increment above so the write wins.
        case (commit_csr)
          CSR_MSTATUS: begin
            mst_d = mstatus_t'(64'(wval) & MSTATUS_WMASK);
            if (wval[12:11] == 2'b01 || wval[12:11] == 2'b10) mst_d.mpp = mst_q.mpp;
          end
          CSR_MIE: mie_d = wval[NIRQ-1:0];
          CSR_MTVEC: begin
`ifdef CSR_VECTORED_EN
            mtvec_d = {wval[XLEN-1:2], (wval[1:0] <= 2'd1) ? wval[1:0] : mtvec_q[1:0]};
`else
            mtvec_d = wval & XLEN'(MTVEC_BASE_MASK);
`endif
          end
          CSR_MSCRATCH: mscratch_d = wval;
          CSR_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause_d   = wval;
          CSR_MTVAL:    mtval_d    = wval;
          CSR_SATP:     satp_d     = wval;
          CSR_MCYCLE:   mcycle_d   = wval;
          CSR_MINSTRET: minstret_d = wval;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      priv_q           <= PRIV_M;
      mst_q            <= '0;
      mie_q            <= '0;
      mtvec_q          <= RESET_VEC & XLEN'(MTVEC_BASE_MASK);
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      satp_q           <= '0;
      mcycle_q         <= '0;
      minstret_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      priv_q           <= priv_d;
      mst_q            <= mst_d;
      mie_q            <= mie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      satp_q           <= satp_d;
      mcycle_q         <= mcycle_d;
      minstret_q       <= minstret_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
    end
  end

endmodule

// File: tb/tb_csr_mfile.sv
// Directed bench for csr_mfile; expectations for vectored entry follow CSR_VECTORED_EN.
module tb_csr_mfile;
  import csr_pkg::*;

  logic        clk, reset;
  logic [11:0] csr_ra;
  logic [63:0] csr_rd;
  logic        commit_valid, commit_ready, commit_stall;
  logic [63:0] commit_pc, commit_wdata, commit_tval;
  csr_op_t     commit_op;
  logic [11:0] commit_csr;
  logic        commit_wzero, commit_exc;
  logic [3:0]  commit_cause;
  logic [11:0] irq;
  logic        redirect_valid, redirect_ready, flush;
  logic [63:0] redirect_pc;
  logic [1:0]  priv;
  csr_state_e  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

`ifdef CSR_VECTORED_EN
  localparam logic [63:0] MTVEC_RD = 64'h8000_1001;
  localparam logic [63:0] TGT_I7   = 64'h8000_101C;
  localparam logic [63:0] TGT_I11  = 64'h8000_102C;
  localparam logic [63:0] TGT_I3   = 64'h8000_100C;
`else
  localparam logic [63:0] MTVEC_RD = 64'h8000_1000;
  localparam logic [63:0] TGT_I7   = 64'h8000_1000;
  localparam logic [63:0] TGT_I11  = 64'h8000_1000;
  localparam logic [63:0] TGT_I3   = 64'h8000_1000;
`endif
  localparam logic [63:0] BASE = 64'h8000_1000;

  csr_mfile dut (
    .clk(clk), .reset(reset), .csr_ra(csr_ra), .csr_rd(csr_rd),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_stall(commit_stall),
    .commit_pc(commit_pc), .commit_op(commit_op), .commit_csr(commit_csr),
    .commit_wdata(commit_wdata), .commit_wzero(commit_wzero), .commit_exc(commit_exc),
    .commit_cause(commit_cause), .commit_tval(commit_tval), .irq(irq),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush), .priv(priv), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    csr_ra = addr;
    #1;
    chk(tag, csr_rd, exp);
  endtask

  // Presents one instruction at a negedge; it is accepted at the next posedge.
  task automatic commit(input csr_op_t op, input logic [63:0] pc, input logic [11:0] csr,
                        input logic [63:0] wd, input logic wz);
    commit_op = op; commit_pc = pc; commit_csr = csr;
    commit_wdata = wd; commit_wzero = wz; commit_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    commit_valid = 1'b0; commit_op = OP_NONE; commit_wzero = 1'b0;
    commit_exc = 1'b0; commit_cause = 4'd0; commit_tval = '0;
  endtask

  task automatic redir(input string tag, input logic [63:0] pc);
    chk({tag, ".rv"}, {63'd0, redirect_valid}, 64'd1);
    chk({tag, ".flush"}, {63'd0, flush}, 64'd1);
    chk({tag, ".pc"}, redirect_pc, pc);
    redirect_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    redirect_ready = 1'b0;
    chk({tag, ".rv_clr"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, ".flush_clr"}, {63'd0, flush}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; csr_ra = '0; commit_valid = 1'b0; commit_stall = 1'b0;
    commit_pc = '0; commit_op = OP_NONE; commit_csr = '0; commit_wdata = '0;
    commit_wzero = 1'b0; commit_exc = 1'b0; commit_cause = '0; commit_tval = '0;
    irq = '0; redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    chk("rst.priv", {62'd0, priv}, 64'd3);
    chk("rst.ready", {63'd0, commit_ready}, 64'd1);
    chk("rst.rv", {63'd0, redirect_valid}, 64'd0);
    chk("rst.flush", {63'd0, flush}, 64'd0);
    rdchk("rst.mtvec", CSR_MTVEC, 64'h8000_0000);
    rdchk("rst.mstatus", CSR_MSTATUS, 64'd0);

    commit(OP_CSRRW, 64'h100, CSR_MTVEC, 64'h8000_1000, 1'b0);
    redir("rw_mtvec", 64'h104);
    rdchk("mtvec.rw", CSR_MTVEC, 64'h8000_1000);
    commit(OP_CSRRS, 64'h104, CSR_MTVEC, 64'h1, 1'b0);
    redir("rs_mtvec", 64'h108);
    rdchk("mtvec.rs", CSR_MTVEC, MTVEC_RD);
    // Mode 2 is not a legal encoding; the previous mode must survive.
    commit(OP_CSRRW, 64'h108, CSR_MTVEC, 64'h8000_1002, 1'b0);
    redir("rw_mtvec2", 64'h10C);
    rdchk("mtvec.mode2", CSR_MTVEC, MTVEC_RD);

    commit(OP_CSRRW, 64'h10C, CSR_MIE, 64'hF080, 1'b0);
    redir("rw_mie", 64'h110);
    rdchk("mie.mask", CSR_MIE, 64'h80);
    commit(OP_CSRRW, 64'h110, CSR_MSTATUS, 64'h1008, 1'b0);
    redir("rw_mstatus", 64'h114);
    rdchk("mstatus.warl", CSR_MSTATUS, 64'h8);

    irq = 12'h080;
    rdchk("mip.read", CSR_MIP, 64'h80);
    commit(OP_NONE, 64'h8000_0040, 12'h0, 64'h0, 1'b0);
    irq = '0;
    redir("irq7", TGT_I7);
    rdchk("irq7.mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
    rdchk("irq7.mepc", CSR_MEPC, 64'h8000_0040);
    rdchk("irq7.mstatus", CSR_MSTATUS, 64'h1880);
    rdchk("irq7.minstret", CSR_MINSTRET, 64'd5);

    commit(OP_CSRRW, 64'h200, CSR_MIE, 64'h888, 1'b0);
    redir("rw_mie2", 64'h204);
    commit(OP_CSRRW, 64'h204, CSR_MSTATUS, 64'h1888, 1'b0);
    redir("rw_mstatus2", 64'h208);
    rdchk("mstatus.1888", CSR_MSTATUS, 64'h1888);
    irq = 12'h888;
    commit(OP_NONE, 64'h300, 12'h0, 64'h0, 1'b0);
    irq = '0;
    redir("irq11", TGT_I11);
    rdchk("irq11.mcause", CSR_MCAUSE, 64'h8000_0000_0000_000B);

    commit(OP_MRET, 64'h304, 12'h0, 64'h0, 1'b0);
    redir("mret_m", 64'h300);
    chk("mret_m.priv", {62'd0, priv}, 64'd3);
    rdchk("mret_m.mstatus", CSR_MSTATUS, 64'h88);
    irq = 12'h088;
    commit(OP_NONE, 64'h400, 12'h0, 64'h0, 1'b0);
    irq = '0;
    redir("irq3", TGT_I3);
    rdchk("irq3.mcause", CSR_MCAUSE, 64'h8000_0000_0000_0003);
    rdchk("irq3.minstret", CSR_MINSTRET, 64'd8);

    commit(OP_CSRRC, 64'h500, CSR_MSTATUS, 64'h1800, 1'b0);
    redir("rc_mstatus", 64'h504);
    rdchk("rc.mstatus", CSR_MSTATUS, 64'h80);
    commit(OP_CSRRW, 64'h504, CSR_MEPC, 64'h603, 1'b0);
    redir("rw_mepc", 64'h508);
    rdchk("mepc.lowbits", CSR_MEPC, 64'h600);
    commit(OP_MRET, 64'h508, 12'h0, 64'h0, 1'b0);
    redir("mret_u", 64'h600);
    chk("mret_u.priv", {62'd0, priv}, 64'd0);

    commit(OP_ECALL, 64'h600, 12'h0, 64'h0, 1'b0);
    redir("ecall_u", BASE);
    rdchk("ecall_u.mcause", CSR_MCAUSE, 64'd8);
    chk("ecall_u.priv", {62'd0, priv}, 64'd3);
    commit(OP_ECALL, 64'h700, 12'h0, 64'h0, 1'b0);
    redir("ecall_m", BASE);
    rdchk("ecall_m.mcause", CSR_MCAUSE, 64'd11);

    commit(OP_CSRRW, 64'h800, CSR_CYCLE, 64'h5, 1'b0);
    redir("ro_write", BASE);
    rdchk("ro_write.mcause", CSR_MCAUSE, 64'd2);
    commit(OP_CSRRS, 64'h900, CSR_CYCLE, 64'h0, 1'b1);
    redir("ro_read", 64'h904);
    rdchk("ro_read.mcause", CSR_MCAUSE, 64'd2);

    commit_exc = 1'b1; commit_cause = 4'd5; commit_tval = 64'h1234;
    commit(OP_CSRRW, 64'hA02, CSR_MSCRATCH, 64'h1, 1'b0);
    redir("exc", BASE);
    rdchk("exc.mcause", CSR_MCAUSE, 64'd5);
    rdchk("exc.mtval", CSR_MTVAL, 64'h1234);
    rdchk("exc.mepc", CSR_MEPC, 64'hA00);
    rdchk("exc.mscratch", CSR_MSCRATCH, 64'd0);
    commit(OP_CSRRS, 64'hA10, 12'h7C0, 64'h0, 1'b1);
    redir("unimpl", BASE);
    rdchk("unimpl.mcause", CSR_MCAUSE, 64'd2);
    rdchk("unimpl.mtval", CSR_MTVAL, 64'd0);

    commit(OP_NONE, 64'hA14, 12'h0, 64'h0, 1'b0);
    chk("none.rv", {63'd0, redirect_valid}, 64'd0);
    chk("none.flush", {63'd0, flush}, 64'd0);
    chk("none.ready", {63'd0, commit_ready}, 64'd1);
    rdchk("none.minstret", CSR_MINSTRET, 64'd13);

    commit_stall = 1'b1; commit_valid = 1'b1; commit_op = OP_CSRRW;
    commit_csr = CSR_MSCRATCH; commit_wdata = 64'h77; commit_pc = 64'hA18;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    commit_valid = 1'b0; commit_stall = 1'b0;
    chk("stall.rv", {63'd0, redirect_valid}, 64'd0);
    rdchk("stall.mscratch", CSR_MSCRATCH, 64'd0);

    commit(OP_CSRRW, 64'hA20, CSR_MSCRATCH, 64'h55, 1'b0);
    redir("rw_mscratch", 64'hA24);
    commit(OP_CSRRC, 64'hA24, CSR_MSTATUS, 64'h1800, 1'b0);
    redir("rc_mstatus2", 64'hA28);
    commit(OP_MRET, 64'hA28, 12'h0, 64'h0, 1'b0);
    chk("hold.rv0", {63'd0, redirect_valid}, 64'd1);
    chk("hold.pc0", redirect_pc, 64'hA10);
    commit_valid = 1'b1; commit_op = OP_CSRRW; commit_csr = CSR_MSCRATCH;
    commit_wdata = 64'hAA; commit_pc = 64'hA10;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("hold.rv%0d", c), {63'd0, redirect_valid}, 64'd1);
      chk($sformatf("hold.pc%0d", c), redirect_pc, 64'hA10);
      chk($sformatf("hold.ready%0d", c), {63'd0, commit_ready}, 64'd0);
      chk($sformatf("hold.flush%0d", c), {63'd0, flush}, 64'd0);
      chk($sformatf("hold.priv%0d", c), {62'd0, priv}, 64'd0);
      rdchk($sformatf("hold.mscratch%0d", c), CSR_MSCRATCH, 64'h55);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; commit_valid = 1'b0;
    chk("rst2.rv", {63'd0, redirect_valid}, 64'd0);
    chk("rst2.priv", {62'd0, priv}, 64'd3);
    chk("rst2.ready", {63'd0, commit_ready}, 64'd1);
    rdchk("rst2.mscratch", CSR_MSCRATCH, 64'd0);
    rdchk("rst2.mtvec", CSR_MTVEC, 64'h8000_0000);

    commit(OP_CSRRW, 64'h0, CSR_MSCRATCH, 64'h9, 1'b0);
    redir("post_rst", 64'h4);
    rdchk("post_rst.mscratch", CSR_MSCRATCH, 64'h9);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
